// File: rtl/map_ss_pkg.sv
// Shared definitions for the mapper save-state sequencer: FSM states,
// transfer direction encoding and the CRC-8 step used by MAP_SS_CRC_EN builds.
package map_ss_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SEND,
        ST_RECV,
        ST_WRITE,
        ST_CHECK,
        ST_FINISH
    } state_t;

    localparam logic DIR_SAVE    = 1'b0;
    localparam logic DIR_RESTORE = 1'b1;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // MSB-first CRC-8 over one byte.
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/map_ss_crc8.sv
// Byte-serial CRC-8 accumulator; crc_next exposes the value after absorbing
// the current data byte so the caller can use it in the same cycle.
module map_ss_crc8
    import map_ss_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] crc,
    output logic [7:0] crc_next
);

    assign crc_next = crc8_update(crc, data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= 8'h00;
        end else if (clear) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= crc_next;
        end
    end

endmodule

// File: rtl/map_ss_seq.sv
// Save-state sequencer for mapper register banks: streams mapper state bytes
// out on save and replays them as ss_we writes on restore. Optional trailing
// CRC-8 byte is enabled by defining MAP_SS_CRC_EN.
module map_ss_seq
    import map_ss_pkg::*;
#(
    parameter int NUM_REGS = 3,
    parameter int IDX_ADDR = 127,
    parameter int RD_LAT   = 2,
    parameter int WE_CYC   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dir,
    input  logic       abort,
    output logic       ss_act,
    output logic       ss_we,
    output logic [7:0] ss_addr,
    output logic [7:0] ss_wdat,
    input  logic [7:0] ss_rdat,
    output logic [7:0] out_dat,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic [7:0] in_dat,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_t     state, state_n;
    logic [7:0] addr_q, addr_n;
    logic [7:0] cnt, cnt_n;
    logic [7:0] cap, cap_n;
    logic [7:0] dat_q, dat_n;
    logic       err_q, err_n;
    logic [7:0] addr_adv;
    logic       at_idx;

`ifdef MAP_SS_CRC_EN
    logic       crc_phase, crc_phase_n;
    logic       crc_clr, crc_en;
    logic [7:0] crc_din, crc_q, crc_nx;

    map_ss_crc8 u_crc (
        .clk      (clk),
        .rst      (rst),
        .clear    (crc_clr),
        .en       (crc_en),
        .data     (crc_din),
        .crc      (crc_q),
        .crc_next (crc_nx)
    );
`endif

    // The index byte sits outside the contiguous register window, so the
    // address jumps straight to it after the last register.
    assign addr_adv = (addr_q == 8'(NUM_REGS - 1)) ? 8'(IDX_ADDR) : addr_q + 8'd1;
    assign at_idx   = (addr_q == 8'(IDX_ADDR));

    // Direction is not stored: the branch taken out of IDLE already encodes it.
    always_comb begin
        state_n = state;
        addr_n  = addr_q;
        cnt_n   = cnt;
        cap_n   = cap;
        dat_n   = dat_q;
        err_n   = err_q;
`ifdef MAP_SS_CRC_EN
        crc_phase_n = crc_phase;
        crc_clr     = 1'b0;
        crc_en      = 1'b0;
        crc_din     = 8'h00;
`endif
        if (abort && state != ST_IDLE) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        err_n   = 1'b0;
                        addr_n  = 8'h00;
                        cnt_n   = '0;
                        state_n = (dir == DIR_RESTORE) ? ST_RECV : ST_SETUP;
`ifdef MAP_SS_CRC_EN
                        crc_phase_n = 1'b0;
                        crc_clr     = 1'b1;
`endif
                    end
                end
                ST_SETUP: begin
                    if (cnt == 8'(RD_LAT - 1)) begin
                        cnt_n   = '0;
                        dat_n   = ss_rdat;
                        state_n = ST_SEND;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
                ST_SEND: begin
                    if (out_ready) begin
`ifdef MAP_SS_CRC_EN
                        if (crc_phase) begin
                            state_n = ST_FINISH;
                        end else begin
                            crc_en  = 1'b1;
                            crc_din = dat_q;
                            if (at_idx) begin
                                crc_phase_n = 1'b1;
                                dat_n       = crc_nx;
                            end else begin
                                addr_n  = addr_adv;
                                state_n = ST_SETUP;
                            end
                        end
`else
                        if (at_idx) begin
                            state_n = ST_FINISH;
                        end else begin
                            addr_n  = addr_adv;
                            state_n = ST_SETUP;
                        end
`endif
                    end
                end
                ST_RECV: begin
                    if (in_valid) begin
                        cap_n = in_dat;
`ifdef MAP_SS_CRC_EN
                        if (crc_phase) begin
                            if (in_dat != crc_q) begin
                                err_n = 1'b1;
                            end
                            state_n = ST_FINISH;
                        end else begin
                            crc_en  = 1'b1;
                            crc_din = in_dat;
                            state_n = at_idx ? ST_CHECK : ST_WRITE;
                        end
`else
                        state_n = at_idx ? ST_CHECK : ST_WRITE;
`endif
                    end
                end
                ST_WRITE: begin
                    if (cnt == 8'(WE_CYC - 1)) begin
                        cnt_n   = '0;
                        addr_n  = addr_adv;
                        state_n = ST_RECV;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
                ST_CHECK: begin
                    // The index byte is only compared, never written back.
                    if (cnt == 8'(RD_LAT - 1)) begin
                        cnt_n = '0;
                        if (ss_rdat != cap) begin
                            err_n   = 1'b1;
                            state_n = ST_FINISH;
                        end else begin
`ifdef MAP_SS_CRC_EN
                            crc_phase_n = 1'b1;
                            state_n     = ST_RECV;
`else
                            state_n = ST_FINISH;
`endif
                        end
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
                ST_FINISH: state_n = ST_IDLE;
                default:   state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            addr_q <= 8'h00;
            cnt    <= '0;
            cap    <= 8'h00;
            dat_q  <= 8'h00;
            err_q  <= 1'b0;
`ifdef MAP_SS_CRC_EN
            crc_phase <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            addr_q <= addr_n;
            cnt    <= cnt_n;
            cap    <= cap_n;
            dat_q  <= dat_n;
            err_q  <= err_n;
`ifdef MAP_SS_CRC_EN
            crc_phase <= crc_phase_n;
`endif
        end
    end

    // Strobes decode straight from the state register so a reset drops them
    // immediately rather than a cycle later.
    assign ss_act    = state inside {ST_SETUP, ST_SEND, ST_RECV, ST_WRITE, ST_CHECK};
    assign busy      = ss_act;
    assign ss_we     = (state == ST_WRITE);
    assign out_valid = (state == ST_SEND);
    assign in_ready  = (state == ST_RECV);
    assign done      = (state == ST_FINISH);
    assign ss_addr   = addr_q;
    assign ss_wdat   = cap;
    assign out_dat   = dat_q;
    assign err       = err_q;

endmodule

// File: tb/tb_map_ss_seq.sv
// Self-checking bench for map_ss_seq with a behavioural mapper and host model;
// expectations include the trailing CRC byte when MAP_SS_CRC_EN is defined.
module tb_map_ss_seq;

    localparam int NUM_REGS = 3;
    localparam int IDX_ADDR = 127;
    localparam int RD_LAT   = 2;
    localparam int WE_CYC   = 4;
`ifdef MAP_SS_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, start, dir, abort, out_ready, in_valid;
    logic [7:0] in_dat;
    logic       ss_act, ss_we, out_valid, in_ready, busy, done, err;
    logic [7:0] ss_addr, ss_wdat, ss_rdat, out_dat;

    logic [7:0] mregs [0:255];
    assign ss_rdat = mregs[ss_addr];

    always #5 clk = ~clk;

    map_ss_seq #(.NUM_REGS(NUM_REGS), .IDX_ADDR(IDX_ADDR), .RD_LAT(RD_LAT), .WE_CYC(WE_CYC)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .abort(abort),
        .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr), .ss_wdat(ss_wdat), .ss_rdat(ss_rdat),
        .out_dat(out_dat), .out_valid(out_valid), .out_ready(out_ready),
        .in_dat(in_dat), .in_valid(in_valid), .in_ready(in_ready),
        .busy(busy), .done(done), .err(err)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] host_q[$];
    logic [7:0] got_dat[$];
    logic [7:0] got_addr[$];
    logic [7:0] we_addr[$];
    int         we_len[$];
    int         done_cnt, stab_viol;
    logic       err_at_done;
    bit         post_valid;
    logic       post_we, post_act, post_busy;

    function automatic logic [7:0] crc8_of(input logic [7:0] q[$]);
        logic [7:0] c;
        c = 8'h00;
        foreach (q[i]) begin
            c ^= q[i];
            for (int b = 0; b < 8; b++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    // Drives one operation cycle by cycle, acting as host and as mapper.
    // The mapper commits a write only when a strobe of full WE_CYC length ends.
    task automatic run_op(input logic d, input int rmode, input int abort_pulse, input int max_cyc,
                          output bit finished);
        int         run, pulse_no, after;
        bit         fire, fired, abort_seen, in_acc, stall;
        logic [7:0] w_addr, w_dat, stall_dat;
        got_dat.delete(); got_addr.delete(); we_addr.delete(); we_len.delete();
        done_cnt = 0; stab_viol = 0; post_valid = 0; err_at_done = 1'bx;
        run = 0; pulse_no = 0; after = 0; fire = 0; fired = 0; abort_seen = 0; stall = 0;
        finished = 0; w_addr = 8'h00; w_dat = 8'h00; stall_dat = 8'h00;
        @(posedge clk); #1;
        start = 1'b1; dir = d; abort = 1'b0;
        in_valid = (host_q.size() > 0);
        in_dat = (host_q.size() > 0) ? host_q[0] : 8'h00;
        out_ready = (rmode == 0);
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (abort_seen && !post_valid) begin
                post_we = ss_we; post_act = ss_act; post_busy = busy; post_valid = 1;
            end
            if (abort === 1'b1) abort_seen = 1;
            if (out_valid && out_ready && !abort) begin
                got_dat.push_back(out_dat);
                got_addr.push_back(ss_addr);
            end
            if (stall && out_valid && out_dat !== stall_dat) stab_viol++;
            stall = out_valid && !out_ready && !abort;
            stall_dat = out_dat;
            in_acc = in_valid && in_ready && !abort;
            if (ss_we === 1'b1) begin
                if (run == 0) begin
                    w_addr = ss_addr; w_dat = ss_wdat; pulse_no++;
                    if (pulse_no == abort_pulse) fire = 1;
                end else if (ss_addr !== w_addr) begin
                    stab_viol++;
                end
                run++;
            end else if (run > 0) begin
                we_addr.push_back(w_addr);
                we_len.push_back(run);
                if (run == WE_CYC) mregs[w_addr] = w_dat;
                run = 0;
            end
            if (done === 1'b1) begin
                done_cnt++; err_at_done = err; finished = 1;
            end
            @(posedge clk); #1;
            start = 1'b0; abort = 1'b0;
            if (fire && !fired) begin abort = 1'b1; fired = 1; end
            if (in_acc) void'(host_q.pop_front());
            in_valid = (host_q.size() > 0) && (rmode != 2 || $urandom_range(0, 1) == 1);
            in_dat = (host_q.size() > 0) ? host_q[0] : 8'h00;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (c % 3 == 2);
                default: out_ready = ($urandom_range(0, 1) == 1);
            endcase
            if (finished) break;
            if (post_valid) begin
                after++;
                if (after >= 3) break;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
        host_q.delete();
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({ss_act, ss_we, out_valid, in_ready, busy, done, err} !== 7'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_flags: got %b, expected 0000000", {ss_act, ss_we, out_valid, in_ready, busy, done, err});
        end
        n_cmp++;
        if ({ss_addr, ss_wdat, out_dat} !== 24'h0) begin
            n_bad++;
            $display("[TB] FAIL reset_buses: got %06h, expected 000000", {ss_addr, ss_wdat, out_dat});
        end
    endtask

    task automatic test_save(input string name, input int rmode);
        logic [7:0] exp_dat[$];
        logic [7:0] exp_addr[$];
        bit         fin;
        for (int i = 0; i < NUM_REGS; i++) begin
            exp_dat.push_back(mregs[i]); exp_addr.push_back(8'(i));
        end
        exp_dat.push_back(mregs[IDX_ADDR]); exp_addr.push_back(8'(IDX_ADDR));
        if (CRC_ON) begin
            exp_dat.push_back(crc8_of(exp_dat)); exp_addr.push_back(8'(IDX_ADDR));
        end
        run_op(1'b0, rmode, 0, 300, fin);
        n_cmp++;
        if (fin !== 1'b1) begin n_bad++; $display("[TB] FAIL %s_timeout: got no done, expected done", name); end
        n_cmp++;
        if (got_dat.size() != exp_dat.size()) begin
            n_bad++; $display("[TB] FAIL %s_count: got %0d bytes, expected %0d", name, got_dat.size(), exp_dat.size());
        end
        for (int i = 0; i < exp_dat.size() && i < got_dat.size(); i++) begin
            n_cmp++;
            if (got_dat[i] !== exp_dat[i] || got_addr[i] !== exp_addr[i]) begin
                n_bad++;
                $display("[TB] FAIL %s_byte%0d: got %02h@%0d, expected %02h@%0d", name, i, got_dat[i], got_addr[i], exp_dat[i], exp_addr[i]);
            end
        end
        n_cmp++;
        if (done_cnt !== 1 || err_at_done !== 1'b0 || stab_viol !== 0) begin
            n_bad++;
            $display("[TB] FAIL %s_status: got done=%0d err=%b unstable=%0d, expected 1 0 0", name, done_cnt, err_at_done, stab_viol);
        end
    endtask

    task automatic test_restore(input string name, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] idx, input int rmode);
        logic [7:0] bytes[$];
        logic [7:0] old_idx;
        logic       exp_err;
        bit         fin;
        bytes = '{b0, b1, b2, idx};
        old_idx = mregs[IDX_ADDR];
        exp_err = (idx != old_idx);
        host_q = bytes;
        if (CRC_ON) host_q.push_back(crc8_of(bytes));
        run_op(1'b1, rmode, 0, 400, fin);
        n_cmp++;
        if (fin !== 1'b1) begin n_bad++; $display("[TB] FAIL %s_timeout: got no done, expected done", name); end
        n_cmp++;
        if (we_addr.size() != NUM_REGS) begin
            n_bad++; $display("[TB] FAIL %s_we_count: got %0d, expected %0d", name, we_addr.size(), NUM_REGS);
        end
        for (int i = 0; i < NUM_REGS && i < we_addr.size(); i++) begin
            n_cmp++;
            if (we_addr[i] !== 8'(i) || we_len[i] !== WE_CYC || mregs[i] !== bytes[i]) begin
                n_bad++;
                $display("[TB] FAIL %s_write%0d: got addr %0d len %0d reg %02h, expected addr %0d len %0d reg %02h",
                         name, i, we_addr[i], we_len[i], mregs[i], i, WE_CYC, bytes[i]);
            end
        end
        n_cmp++;
        if (mregs[IDX_ADDR] !== old_idx) begin
            n_bad++; $display("[TB] FAIL %s_idx_kept: got %02h, expected %02h", name, mregs[IDX_ADDR], old_idx);
        end
        n_cmp++;
        if (done_cnt !== 1 || err_at_done !== exp_err) begin
            n_bad++; $display("[TB] FAIL %s_status: got done=%0d err=%b, expected 1 %b", name, done_cnt, err_at_done, exp_err);
        end
        n_cmp++;
        if (err !== exp_err || busy !== 1'b0) begin
            n_bad++; $display("[TB] FAIL %s_idle: got err=%b busy=%b, expected %b 0", name, err, busy, exp_err);
        end
    endtask

    task automatic test_abort();
        bit fin;
        mregs[0] = 8'h11; mregs[1] = 8'h22; mregs[IDX_ADDR] = 8'h2A;
        host_q = '{8'h3B, 8'h12, 8'h07, 8'h2A};
        run_op(1'b1, 0, 2, 200, fin);
        n_cmp++;
        if (post_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL abort_reached: got no abort, expected abort"); end
        n_cmp++;
        if ({post_we, post_act, post_busy} !== 3'b000) begin
            n_bad++; $display("[TB] FAIL abort_next_cycle: got we/act/busy=%b, expected 000", {post_we, post_act, post_busy});
        end
        n_cmp++;
        if (done_cnt !== 0) begin n_bad++; $display("[TB] FAIL abort_no_done: got %0d, expected 0", done_cnt); end
        n_cmp++;
        if (mregs[0] !== 8'h3B || mregs[1] !== 8'h22) begin
            n_bad++; $display("[TB] FAIL abort_regs: got %02h %02h, expected 3b 22", mregs[0], mregs[1]);
        end
    endtask

    task automatic test_reset_mid_send();
        bit seen;
        seen = 0;
        @(posedge clk); #1;
        start = 1'b1; dir = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1;
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (seen !== 1'b1 || {ss_act, ss_we, out_valid, busy, done, err} !== 6'b0 || {ss_addr, out_dat} !== 16'h0) begin
            n_bad++;
            $display("[TB] FAIL reset_mid_send: got seen=%b flags=%b bus=%04h, expected 1 000000 0000",
                     seen, {ss_act, ss_we, out_valid, busy, done, err}, {ss_addr, out_dat});
        end
        #2 rst = 1'b0;
        test_save("save_after_reset", 0);
    endtask

    task automatic test_idle_abort();
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, ss_act, done} !== 3'b000) begin
            n_bad++; $display("[TB] FAIL idle_abort: got busy/act/done=%b, expected 000", {busy, ss_act, done});
        end
    endtask

    task automatic test_random();
        logic [7:0] r0, r1, r2, ix;
        for (int it = 0; it < 4; it++) begin
            for (int a = 0; a < NUM_REGS; a++) mregs[a] = 8'($urandom);
            mregs[IDX_ADDR] = 8'($urandom);
            test_save($sformatf("rand_save%0d", it), 2);
            r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
            ix = (it % 2 == 0) ? mregs[IDX_ADDR] : (mregs[IDX_ADDR] ^ 8'($urandom_range(1, 255)));
            test_restore($sformatf("rand_restore%0d", it), r0, r1, r2, ix, 2);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; dir = 1'b0; abort = 1'b0;
        out_ready = 1'b0; in_valid = 1'b0; in_dat = 8'h00;
        for (int a = 0; a < 256; a++) mregs[a] = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        #2 rst = 1'b0;

        mregs[0] = 8'hC5; mregs[1] = 8'h34; mregs[2] = 8'h05; mregs[IDX_ADDR] = 8'h2A;
        test_save("save_basic", 0);
        test_save("save_backpressure", 1);
        test_restore("restore_basic", 8'h3B, 8'h12, 8'h07, 8'h2A, 0);
        test_restore("restore_bad_idx", 8'hA1, 8'hB2, 8'hC3, 8'h55, 0);
        test_abort();
        test_idle_abort();
        test_reset_mid_send();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
